// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the pushbutton debounce front end.
// State encoding of the per-channel debounce FSM plus default sizing.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    REL        = 2'd0,
    PRESS_WAIT = 2'd1,
    PRS        = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_e;

  localparam int DEF_N_BTN     = 3;
  localparam int DEF_DB_CYCLES = 500000;
  localparam int DEF_CNT_W     = 19;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, 4-state FSM.
// Latency raw->clean is 2 + DB_CYCLES clocks; no backpressure, strobes are one cycle.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic btn_clean,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            sync1_q, sync2_q;
  db_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            clean_q, clean_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      REL: begin
        clean_d = 1'b1;
        if (!sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRS;
          cnt_d   = '0;
          clean_d = 1'b0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRS: begin
        clean_d = 1'b0;
        if (sync2_q) begin
          state_d = REL_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      REL_WAIT: begin
        if (!sync2_q) begin
          state_d = PRS;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = REL;
          cnt_d     = '0;
          clean_d   = 1'b1;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
        clean_d = 1'b1;
      end
    endcase
  end

  // Synchroniser idles high so a released button looks stable out of reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= REL;
      cnt_q     <= '0;
      clean_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_clean   = clean_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounce front end for N_BTN active-low pushbuttons, one independent channel each.
// Latency 2 + DB_CYCLES clocks per accepted edge; no backpressure.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN     = DEF_N_BTN,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .CLK         (CLK),
      .RST         (RST),
      .btn_raw     (btn_raw[i]),
      .btn_clean   (btn_clean[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with DB_CYCLES = 4, N_BTN = 3.
module tb_btn_debounce;

  localparam int NB = 3;
  localparam int DB = 4;
  localparam int LAT = 2 + DB;

  logic          CLK;
  logic          RST;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_clean;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  btn_debounce #(
    .N_BTN     (NB),
    .DB_CYCLES (DB),
    .CNT_W     (3)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .btn_raw     (btn_raw),
    .btn_clean   (btn_clean),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  typedef struct {
    int            cyc;
    logic [NB-1:0] clean;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
  } exp_t;

  exp_t          sb_q[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [NB-1:0] exp_clean = '1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected output change lands on clock cyc_now + LAT.
  task automatic push(input logic [NB-1:0] clean, input logic [NB-1:0] press,
                      input logic [NB-1:0] rel);
    exp_t e;
    e.cyc = cyc + LAT;
    e.clean = clean;
    e.press = press;
    e.rel = rel;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    logic [NB-1:0] ep;
    logic [NB-1:0] er;
    int            hit;
    ep = '0;
    er = '0;
    hit = -1;
    if (!RST) begin
      exp_clean = '1;
    end else begin
      for (int i = 0; i < sb_q.size(); i++)
        if (hit < 0 && sb_q[i].cyc == cyc) hit = i;
      if (hit >= 0) begin
        exp_clean = sb_q[hit].clean;
        ep = sb_q[hit].press;
        er = sb_q[hit].rel;
        sb_q.delete(hit);
      end
    end
    check("clean", 32'(btn_clean), 32'(exp_clean));
    check("press", 32'(btn_press), 32'(ep));
    check("release", 32'(btn_release), 32'(er));
  end

  initial begin
    RST = 1'b0;
    btn_raw = 3'b000;
    tick(3);

    // Buttons already held low out of reset.
    RST = 1'b1;
    push(3'b000, 3'b111, 3'b000);
    tick(8);
    btn_raw = 3'b111;
    push(3'b111, 3'b000, 3'b111);
    tick(8);

    // Clean press on channel 0.
    btn_raw = 3'b110;
    push(3'b110, 3'b001, 3'b000);
    tick(8);

    // Bouncing press on channel 1, only the final stable low counts.
    btn_raw[1] = 1'b0; tick(2);
    btn_raw[1] = 1'b1; tick(2);
    btn_raw[1] = 1'b0; tick(2);
    btn_raw[1] = 1'b1; tick(2);
    btn_raw[1] = 1'b0;
    push(3'b100, 3'b010, 3'b000);
    tick(8);

    // Channel 2: press, short release glitch, then real release.
    btn_raw[2] = 1'b0;
    push(3'b000, 3'b100, 3'b000);
    tick(8);
    btn_raw[2] = 1'b1; tick(3);
    btn_raw[2] = 1'b0; tick(8);
    btn_raw[2] = 1'b1;
    push(3'b100, 3'b000, 3'b100);
    tick(8);

    // All channels together.
    btn_raw = 3'b111;
    push(3'b111, 3'b000, 3'b011);
    tick(8);
    btn_raw = 3'b000;
    push(3'b000, 3'b111, 3'b000);
    tick(8);
    btn_raw = 3'b111;
    push(3'b111, 3'b000, 3'b111);
    tick(8);

    // Reset while channel 0 is mid-debounce (cnt = 2).
    btn_raw = 3'b110;
    tick(4);
    RST = 1'b0;
    btn_raw = 3'b111;
    tick(2);
    RST = 1'b1;
    tick(12);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
